// File: rtl/credit_delay_buffer.sv
// Credit-gated FIFO that sits behind a fixed-latency, push-only delay line. It turns
// the delay-line output into a ready/valid stream, so the delay line never has to stall.
module credit_delay_buffer #(
  parameter int unsigned  NumEntries  = 4,
  parameter type          dtype       = logic,
  parameter bit           ChkProtocol = 1'b1,
  localparam int unsigned CntWidth    = $clog2(NumEntries + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                pipe_valid_i,
  input  dtype                pipe_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output dtype                out_data_o,
  output logic [CntWidth-1:0] credits_o,
  output logic [CntWidth-1:0] usage_o,
  output logic                overflow_o
);

  localparam int unsigned         PtrWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [CntWidth-1:0] Depth    = CntWidth'(NumEntries);
  localparam logic [PtrWidth-1:0] LastIdx  = PtrWidth'(NumEntries - 1);

  logic [CntWidth-1:0]   credits_q, credits_d;
  logic [CntWidth-1:0]   usage_q, usage_d;
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic                  overflow_q, overflow_d;
  logic                  launch, push, pop, full, wr_en;
  logic [NumEntries-1:0] slot_we;
  dtype                  mem_q [NumEntries];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ready_o  = (credits_q != '0);
    out_valid_o = (usage_q != '0);
    launch      = in_valid_i & in_ready_o;
    push        = pipe_valid_i;
    pop         = out_valid_o & out_ready_i;
    full        = (usage_q == Depth);
    // A push into a full FIFO is only accepted if the head leaves in the same cycle.
    wr_en       = push & (~full | pop);
  end

  always_comb begin
    credits_d = credits_q;
    if (launch && !pop) begin
      credits_d = credits_q - 1'b1;
    end else if (pop && !launch && credits_q != Depth) begin
      credits_d = credits_q + 1'b1;
    end

    usage_d = usage_q;
    if (wr_en && !pop) begin
      usage_d = usage_q + 1'b1;
    end else if (pop && !wr_en) begin
      usage_d = usage_q - 1'b1;
    end

    rptr_d     = pop ? ptr_inc(rptr_q) : rptr_q;
    wptr_d     = wr_en ? ptr_inc(wptr_q) : wptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_comb begin
    slot_we = '0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      slot_we[i] = wr_en && (wptr_q == PtrWidth'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q  <= Depth;
      usage_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      usage_q    <= usage_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        if (slot_we[i]) begin
          mem_q[i] <= pipe_data_i;
        end
      end
    end
  end

  always_comb begin
    out_data_o = mem_q[rptr_q];
    credits_o  = credits_q;
    usage_o    = usage_q;
    overflow_o = overflow_q;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni || !ChkProtocol)
    !(pipe_valid_i && full && !pop));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (credits_q <= Depth) && !(pop && credits_q == Depth));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_credit_delay_buffer.sv
// Bench for credit_delay_buffer: two instances (4 and 3 entries), each behind a
// 3-cycle delay line, checked by a scoreboard plus a count-level reference model.
module tb_credit_delay_buffer;
  localparam int unsigned Lat = 3;
  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_in_valid = 1'b0, a_out_ready = 1'b0, a_inj = 1'b0;
  logic a_in_ready, a_pipe_valid, a_out_valid, a_overflow;
  byte_t a_in_data = '0, a_inj_data = '0;
  byte_t a_pipe_data, a_out_data;
  logic [2:0] a_credits, a_usage;
  logic [Lat-1:0] a_dl_v;
  byte_t a_dl_d [Lat];

  logic b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic b_in_ready, b_pipe_valid, b_out_valid, b_overflow;
  byte_t b_in_data = '0;
  byte_t b_pipe_data, b_out_data;
  logic [1:0] b_credits, b_usage;
  logic [Lat-1:0] b_dl_v;
  byte_t b_dl_d [Lat];

  // Delay lines share the reset so in-flight beats vanish with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dl_v <= '0;
      b_dl_v <= '0;
    end else begin
      a_dl_v <= {a_dl_v[Lat-2:0], a_in_valid & a_in_ready};
      b_dl_v <= {b_dl_v[Lat-2:0], b_in_valid & b_in_ready};
      a_dl_d[0] <= a_in_data;
      b_dl_d[0] <= b_in_data;
      for (int i = 1; i < Lat; i++) begin
        a_dl_d[i] <= a_dl_d[i-1];
        b_dl_d[i] <= b_dl_d[i-1];
      end
    end
  end

  assign a_pipe_valid = a_dl_v[Lat-1] | a_inj;
  assign a_pipe_data  = a_inj ? a_inj_data : a_dl_d[Lat-1];
  assign b_pipe_valid = b_dl_v[Lat-1];
  assign b_pipe_data  = b_dl_d[Lat-1];

  credit_delay_buffer #(.NumEntries(4), .dtype(byte_t), .ChkProtocol(1'b0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .pipe_valid_i(a_pipe_valid), .pipe_data_i(a_pipe_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .credits_o(a_credits), .usage_o(a_usage), .overflow_o(a_overflow)
  );

  credit_delay_buffer #(.NumEntries(3), .dtype(byte_t)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .pipe_valid_i(b_pipe_valid), .pipe_data_i(b_pipe_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .credits_o(b_credits), .usage_o(b_usage), .overflow_o(b_overflow)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned m_cred [2] = '{4, 3};
  int unsigned m_use  [2] = '{0, 0};
  bit          m_ovf  [2] = '{0, 0};
  bit          m_stall[2] = '{0, 0};
  byte_t       m_prev [2];
  int unsigned n_out  [2] = '{0, 0};
  byte_t exp_a[$];
  byte_t exp_b[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: credits = depth - outstanding beats, usage = pushes - pops,
  // output order = launch order, pushes into a full FIFO without a pop are lost.
  task automatic step(input int d, input int unsigned depth,
                      input logic iv, input logic ir, input logic pv,
                      input logic ov, input logic ordy, input logic ovf,
                      input byte_t idata, input byte_t odata,
                      input int unsigned cr, input int unsigned us);
    bit launch, pop;
    byte_t head;
    int unsigned sz;
    string tag;
    tag = (d == 0) ? "A" : "B";
    chk({tag, ".in_ready"}, ir, m_cred[d] != 0);
    chk({tag, ".credits"}, cr, m_cred[d]);
    chk({tag, ".usage"}, us, m_use[d]);
    chk({tag, ".out_valid"}, ov, m_use[d] != 0);
    chk({tag, ".overflow"}, ovf, m_ovf[d]);
    if (m_stall[d]) chk({tag, ".stable"}, odata, m_prev[d]);
    if (ov && ordy) begin
      sz = (d == 0) ? exp_a.size() : exp_b.size();
      chk({tag, ".out_expected"}, sz != 0, 1);
      if (sz != 0) begin
        if (d == 0) head = exp_a.pop_front();
        else        head = exp_b.pop_front();
        chk({tag, ".out_data"}, odata, head);
        n_out[d]++;
      end
    end
    m_stall[d] = ov && !ordy;
    m_prev[d]  = odata;
    launch = iv && (m_cred[d] != 0);
    pop    = (m_use[d] != 0) && ordy;
    if (launch) begin
      if (d == 0) exp_a.push_back(idata);
      else        exp_b.push_back(idata);
    end
    if (launch && !pop) m_cred[d]--;
    else if (pop && !launch) m_cred[d]++;
    if (pv) begin
      if (m_use[d] < depth || pop) begin
        if (!pop) m_use[d]++;
      end else begin
        m_ovf[d] = 1'b1;
      end
    end else if (pop) begin
      m_use[d]--;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cred  = '{4, 3};
      m_use   = '{0, 0};
      m_ovf   = '{0, 0};
      m_stall = '{0, 0};
      exp_a.delete();
      exp_b.delete();
    end else begin
      step(0, 4, a_in_valid, a_in_ready, a_pipe_valid, a_out_valid, a_out_ready,
           a_overflow, a_in_data, a_out_data, a_credits, a_usage);
      step(1, 3, b_in_valid, b_in_ready, b_pipe_valid, b_out_valid, b_out_ready,
           b_overflow, b_in_data, b_out_data, b_credits, b_usage);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input int unsigned budget);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int unsigned i = 0; i < budget && exp_a.size() != 0; i++) cyc();
    chk("A.drained", exp_a.size(), 0);
  endtask

  initial begin
    int unsigned nacc;
    int unsigned base;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Idle after reset
    chk("rst.in_ready", a_in_ready, 1);
    chk("rst.credits", a_credits, 4);
    chk("rst.usage", a_usage, 0);
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.overflow", a_overflow, 0);
    chk("rst.out_data", a_out_data, 0);
    chk("rst.b_credits", b_credits, 3);

    // Three back-to-back launches, consumer always ready
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'hA1 + i);
      cyc();
    end
    a_in_valid = 1'b0;
    chk("lat.credits_min", a_credits, 1);
    chk("lat.cycle3_valid", a_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lat.valid", a_out_valid, 1);
      chk("lat.data", a_out_data, 8'(8'hA1 + i));
    end
    repeat (3) cyc();
    chk("lat.credits_back", a_credits, 4);

    // Backpressure: only as many launches as entries
    a_out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h30 + i);
      @(negedge clk);
      if (a_in_valid && a_in_ready) nacc++;
      cyc();
    end
    chk("bp.launches", nacc, 4);
    chk("bp.in_ready", a_in_ready, 0);
    chk("bp.usage", a_usage, 4);
    chk("bp.head", a_out_data, 8'h30);
    a_out_ready = 1'b1;
    cyc();
    a_out_ready = 1'b0;
    chk("bp.ready_back", a_in_ready, 1);
    chk("bp.credits_one", a_credits, 1);
    cyc();
    a_in_valid = 1'b0;
    repeat (4) cyc();
    chk("bp.refull", a_usage, 4);

    // Illegal push into full FIFO
    a_inj      = 1'b1;
    a_inj_data = 8'hEE;
    cyc();
    a_inj = 1'b0;
    chk("ovf.set", a_overflow, 1);
    chk("ovf.usage", a_usage, 4);
    repeat (3) cyc();
    chk("ovf.sticky", a_overflow, 1);
    drain_a(30);
    chk("ovf.still_sticky", a_overflow, 1);

    // Reset with beats buffered and in flight
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h60 + i);
      cyc();
    end
    a_in_valid = 1'b0;
    cyc();
    chk("mid.usage", a_usage, 2);
    chk("mid.credits", a_credits, 0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", a_out_valid, 0);
    chk("mid.rst_usage", a_usage, 0);
    chk("mid.rst_credits", a_credits, 4);
    chk("mid.rst_overflow", a_overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_out[0];
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h55;
    cyc();
    a_in_valid = 1'b0;
    for (int unsigned i = 0; i < 20 && n_out[0] == base; i++) cyc();
    chk("mid.beat_out", n_out[0] - base, 1);
    repeat (3) cyc();
    chk("mid.no_stale", n_out[0] - base, 1);

    // Random traffic on the 3-entry instance (pointer wrap)
    for (int i = 0; i < 60; i++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 8'($urandom);
      b_out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int unsigned i = 0; i < 30 && exp_b.size() != 0; i++) cyc();
    chk("B.drained", exp_b.size(), 0);
    chk("B.enough_beats", n_out[1] >= 10, 1);
    chk("B.no_overflow", b_overflow, 0);

    // Random traffic on the 4-entry instance
    for (int i = 0; i < 80; i++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = 8'($urandom);
      a_out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    drain_a(30);
    chk("A.credits_end", a_credits, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
